// File: rtl/timer_display_driver.sv
// Two-digit multiplexed 7-segment driver for the countdown timer.
// Adds leading-zero blanking, a blink while the timer is done, and a one-shot buzzer pulse.
module timer_display_driver #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter int BLINK_HZ    = 2,
    parameter int BUZZ_MS     = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] current_time,
    input  logic       timer_done,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       buzzer
);

    localparam int DIG_CYC  = CLK_FREQ_HZ / REFRESH_HZ;
    localparam int BLK_CYC  = CLK_FREQ_HZ / (2 * BLINK_HZ);
    localparam int BUZZ_CYC = (CLK_FREQ_HZ / 1000) * BUZZ_MS;
    localparam int DIG_W    = $clog2(DIG_CYC);
    localparam int BLK_W    = $clog2(BLK_CYC);
    localparam int BUZZ_W   = $clog2(BUZZ_CYC + 1);

    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIG_CYC - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLK_CYC - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LOAD = BUZZ_W'(BUZZ_CYC);
    localparam logic [6:0]        SEG_OFF   = 7'b1111111;
    localparam logic [1:0]        AN_OFF    = 2'b11;

    // Binary 0..31 to {tens, ones}; inputs above 31 cannot occur.
    function automatic logic [7:0] bin_to_bcd(input logic [4:0] v);
        logic [3:0] tens;
        logic [4:0] ones;
        if (v >= 5'd30) begin
            tens = 4'd3;
            ones = v - 5'd30;
        end else if (v >= 5'd20) begin
            tens = 4'd2;
            ones = v - 5'd20;
        end else if (v >= 5'd10) begin
            tens = 4'd1;
            ones = v - 5'd10;
        end else begin
            tens = 4'd0;
            ones = v;
        end
        return {tens, ones[3:0]};
    endfunction

    // Active-low segment pattern, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [4:0]        t_q, t_d;
    logic              done_q, done_d;
    logic [DIG_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              sel_q, sel_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              phase_q, phase_d;
    logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic [1:0]        an_n_q, an_n_d;
    logic              buzzer_q, buzzer_d;

    logic              done_rise;
    logic              ref_wrap;
    logic              blk_wrap;
    logic [3:0]        tens;
    logic [3:0]        ones;

    // Input stage; done_rise marks the edge on which done_r goes 0 -> 1.
    always_comb begin
        t_d       = current_time;
        done_d    = timer_done;
        done_rise = timer_done & ~done_q;
    end

    always_comb begin
        ref_wrap  = (ref_cnt_q == DIG_LAST);
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
        sel_d     = sel_q ^ ref_wrap;
    end

    // A fresh completion always restarts the blink in the ON phase, even on a wrap.
    always_comb begin
        blk_wrap  = (blk_cnt_q == BLK_LAST);
        blk_cnt_d = blk_cnt_q + 1'b1;
        phase_d   = phase_q;
        if (!done_d || done_rise) begin
            blk_cnt_d = '0;
            phase_d   = 1'b1;
        end else if (blk_wrap) begin
            blk_cnt_d = '0;
            phase_d   = ~phase_q;
        end
    end

    // The buzzer is the registered "counter non-zero" flag, so a load shows up one cycle later.
    always_comb begin
        buzz_cnt_d = buzz_cnt_q;
        if (done_rise) begin
            buzz_cnt_d = BUZZ_LOAD;
        end else if (!done_d) begin
            buzz_cnt_d = '0;
        end else if (buzz_cnt_q != '0) begin
            buzz_cnt_d = buzz_cnt_q - 1'b1;
        end
        buzzer_d = (buzz_cnt_q != '0);
    end

    // Output stage: at most one anode is ever driven low.
    always_comb begin
        {tens, ones} = bin_to_bcd(t_q);
        seg_n_d      = SEG_OFF;
        an_n_d       = AN_OFF;
        if (!(done_q && !phase_q)) begin
            if (!sel_q) begin
                an_n_d  = 2'b10;
                seg_n_d = seg_enc(ones);
            end else if (tens != 4'd0) begin
                an_n_d  = 2'b01;
                seg_n_d = seg_enc(tens);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q        <= '0;
            done_q     <= 1'b0;
            ref_cnt_q  <= '0;
            sel_q      <= 1'b0;
            blk_cnt_q  <= '0;
            phase_q    <= 1'b1;
            buzz_cnt_q <= '0;
            seg_n_q    <= SEG_OFF;
            an_n_q     <= AN_OFF;
            buzzer_q   <= 1'b0;
        end else begin
            t_q        <= t_d;
            done_q     <= done_d;
            ref_cnt_q  <= ref_cnt_d;
            sel_q      <= sel_d;
            blk_cnt_q  <= blk_cnt_d;
            phase_q    <= phase_d;
            buzz_cnt_q <= buzz_cnt_d;
            seg_n_q    <= seg_n_d;
            an_n_q     <= an_n_d;
            buzzer_q   <= buzzer_d;
        end
    end

    assign seg_n  = seg_n_q;
    assign an_n   = an_n_q;
    assign buzzer = buzzer_q;

endmodule

// File: tb/tb_timer_display_driver.sv
// Directed bench for timer_display_driver with DIG_CYC=10, BLK_CYC=10, BUZZ_CYC=5.
module tb_timer_display_driver;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] current_time;
    logic       timer_done;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       buzzer;

    int n_vec  = 0;
    int n_miss = 0;
    int k      = 0;
    int rise_k = 0;

    always #5 clk = ~clk;

    timer_display_driver #(
        .CLK_FREQ_HZ(1000),
        .REFRESH_HZ (100),
        .BLINK_HZ   (50),
        .BUZZ_MS    (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .current_time(current_time),
        .timer_done  (timer_done),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .buzzer      (buzzer)
    );

    task automatic chk_vec(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s k=%0d: got %b, expected %b", tag, k, got, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [1:0] an_e, input logic [6:0] seg_e);
        chk_vec({tag, "_an"}, {5'b0, an_n}, {5'b0, an_e});
        chk_vec({tag, "_seg"}, seg_n, seg_e);
    endtask

    task automatic chk_buz(input string tag, input logic exp);
        chk_vec(tag, {6'b0, buzzer}, {6'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Refresh restarts at reset release: edges 1..10 show ones, 11..20 tens, and so on.
    function automatic bit ones_frame(input int kk);
        return ((kk - 1) / 10) % 2 == 0;
    endfunction

    task automatic run_frames(input logic [4:0] t, input logic [6:0] ones_pat,
                              input logic [6:0] tens_pat, input bit tens_blank);
        current_time = t;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ones_frame(k))
                chk_disp($sformatf("t%0d_ones", t), 2'b10, ones_pat);
            else if (tens_blank)
                chk_disp($sformatf("t%0d_tens_blank", t), 2'b11, SEG_OFF);
            else
                chk_disp($sformatf("t%0d_tens", t), 2'b01, tens_pat);
        end
    endtask

    // Display and buzzer after timer_done rose following edge rise_k, with current_time=0.
    task automatic run_done(input int n);
        int  rel;
        bit  on;
        for (int i = 0; i < n; i++) begin
            tick();
            rel = k - rise_k;
            on  = (rel < 2) || (((rel - 2) / 10) % 2 == 0);
            chk_buz("done_buz", (rel >= 2) && (rel <= 6));
            if (on && ones_frame(k))
                chk_disp("done_zero", 2'b10, SEG_0);
            else
                chk_disp("done_blank", 2'b11, SEG_OFF);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        timer_done   = 1'b0;
        current_time = 5'd0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_disp("rst", 2'b11, SEG_OFF);
            chk_buz("rst_buz", 1'b0);
        end

        rst_n = 1'b1;
        k     = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ones_frame(k)) chk_disp("t0_ones", 2'b10, SEG_0);
            else               chk_disp("t0_tens_blank", 2'b11, SEG_OFF);
            chk_buz("idle_buz", 1'b0);
        end

        run_frames(5'd27, SEG_7, SEG_2, 1'b0);
        run_frames(5'd31, SEG_1, SEG_3, 1'b0);
        run_frames(5'd7,  SEG_7, SEG_OFF, 1'b1);
        run_frames(5'd10, SEG_0, SEG_1, 1'b0);

        // Start the blink out of step with the refresh so an OFF phase lands on a ones frame.
        current_time = 5'd0;
        while (k % 20 != 14) tick();
        timer_done = 1'b1;
        rise_k     = k;
        run_done(41);

        timer_done = 1'b0;
        repeat (3) begin
            tick();
            chk_buz("fall_idle_buz", 1'b0);
        end
        timer_done = 1'b1;
        rise_k     = k;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_buz("pulse_a_buz", i >= 2);
        end
        timer_done = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_buz("early_fall_buz", i == 1);
        end
        timer_done = 1'b1;
        rise_k     = k;
        run_done(25);

        timer_done = 1'b0;
        tick();
        tick();
        timer_done = 1'b1;
        rise_k     = k;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_buz("pre_rst_buz", i >= 2);
        end
        rst_n = 1'b0;
        #1;
        chk_disp("rst_async", 2'b11, SEG_OFF);
        chk_buz("rst_async_buz", 1'b0);
        timer_done = 1'b0;
        repeat (3) begin
            tick();
            chk_disp("rst_hold", 2'b11, SEG_OFF);
            chk_buz("rst_hold_buz", 1'b0);
        end

        rst_n = 1'b1;
        k     = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_buz("post_rst_buz", 1'b0);
            if (ones_frame(k)) chk_disp("post_rst_ones", 2'b10, SEG_0);
            else               chk_disp("post_rst_blank", 2'b11, SEG_OFF);
        end
        timer_done = 1'b1;
        rise_k     = k;
        run_done(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
